// File: rtl/reg_file_sb.sv
// Register file with an integrated write-pending scoreboard for the multicycle core.
// Optional same-cycle writeback bypass on the read ports: define REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_sel,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_sel,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_sel,
  output logic                claim_ok,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [AW:0]      cnt_nxt;
  logic             zero_claim;
  logic             zero_wb;
  logic             claim_pend;
  logic             claim_set;

  assign zero_claim = (ZERO_REG != 0) && (claim_sel == '0);
  assign zero_wb    = (ZERO_REG != 0) && (wb_sel == '0);

  // Claim handshake: claim_en is the request, claim_ok the combinational accept.
  // A claim takes effect only on an edge where both are high; a refused requester holds and retries.
  assign claim_pend = zero_claim ? 1'b0 : pending[claim_sel];
  assign claim_ok   = !claim_pend || (wb_en && (wb_sel == claim_sel));
  assign claim_set  = claim_en && claim_ok && !zero_claim;

  // Writeback clears first so a same-register claim wins; flush overrides both.
  always_comb begin
    pending_nxt = pending;
    if (wb_en)
      pending_nxt[wb_sel] = 1'b0;
    if (claim_set)
      pending_nxt[claim_sel] = 1'b1;
    if (flush)
      pending_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < NREGS; k++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[k]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++)
        regs[k] <= '0;
    end else if (wb_en && !zero_wb) begin
      regs[wb_sel] <= wb_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] sel;
    logic          zsel;
    logic          hit;

    assign sel  = rd_sel[i*AW +: AW];
    assign zsel = (ZERO_REG != 0) && (sel == '0);
`ifdef REG_FILE_SB_BYPASS_EN
    assign hit  = wb_en && (wb_sel == sel) && !zsel;
`else
    assign hit  = 1'b0;
`endif
    assign rd_data[i*XLEN +: XLEN] = zsel ? '0 : (hit ? wb_data : regs[sel]);
    assign rd_busy[i]              = !zsel && !hit && pending[sel];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a random write/readback burst.
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;
`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NRD*AW-1:0]   rd_sel;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wb_en;
  logic [AW-1:0]       wb_sel;
  logic [XLEN-1:0]     wb_data;
  logic                claim_en;
  logic [AW-1:0]       claim_sel;
  logic                claim_ok;
  logic                flush;
  logic [AW:0]         pend_cnt;

  logic [63:0] exp_q[$];
  logic [63:0] e;
  int total = 0;
  int bad = 0;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .claim_en(claim_en),
    .claim_sel(claim_sel), .claim_ok(claim_ok), .flush(flush), .pend_cnt(pend_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    claim_en = 1'b0; claim_sel = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_sel = {b, a};
  endtask

  task automatic drive_wb(input logic [AW-1:0] s, input logic [XLEN-1:0] d);
    wb_en = 1'b1; wb_sel = s; wb_data = d;
  endtask

  task automatic drive_claim(input logic [AW-1:0] s);
    claim_en = 1'b1; claim_sel = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle(); set_rd(5, 5);
    repeat (2) @(negedge clk);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h1);
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL rst_rd0 got=%h exp=%h", rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL rst_busy got=%b exp=%b", rd_busy, e[1:0]); end
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL rst_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL rst_claim_ok got=%b exp=%b", claim_ok, e[0]); end
    reset_n = 1'b1;
    tick();
    // write r5 and claim it on the same edge: data lands, r5 stays pending
    drive_wb(5, 32'h77); drive_claim(5);
    exp_q.push_back(64'h77); exp_q.push_back(64'h1); exp_q.push_back(64'h1);
    tick(); idle(); #1;
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL pre_rst_rd got=%h exp=%h", rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); total++; if (rd_busy[0] !== e[0]) begin bad++; $display("FAIL pre_rst_busy got=%b exp=%b", rd_busy[0], e[0]); end
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL pre_rst_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
    // asynchronous assertion mid-cycle with a claim in flight
    drive_claim(8);
    #1 reset_n = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL mid_rst_rd got=%h exp=%h", rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL mid_rst_busy got=%b exp=%b", rd_busy, e[1:0]); end
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL mid_rst_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
    @(negedge clk); idle(); reset_n = 1'b1;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    tick();
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL post_rst_r5 got=%h exp=%h", rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL post_rst_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
  endtask

  task automatic test_write_read();
    drive_wb(3, 32'hDEADBEEF);
    exp_q.push_back(64'hDEADBEEF_DEADBEEF); exp_q.push_back(64'h0);
    tick(); idle(); set_rd(3, 3); #1;
    e = exp_q.pop_front(); total++; if (rd_data !== e) begin bad++; $display("FAIL wr_rd got=%h exp=%h", rd_data, e); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL wr_busy got=%b exp=%b", rd_busy, e[1:0]); end
  endtask

  task automatic test_zero_reg();
    drive_wb(0, 32'h1234); drive_claim(0); set_rd(0, 3); #1;
    exp_q.push_back(64'h1); exp_q.push_back(64'hDEADBEEF_00000000); exp_q.push_back(64'h0);
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL r0_claim_ok got=%b exp=%b", claim_ok, e[0]); end
    e = exp_q.pop_front(); total++; if (rd_data !== e) begin bad++; $display("FAIL r0_rd got=%h exp=%h", rd_data, e); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL r0_busy got=%b exp=%b", rd_busy, e[1:0]); end
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    tick(); idle(); #1;
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL r0_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL r0_after got=%h exp=%h", rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); total++; if (rd_busy[0] !== e[0]) begin bad++; $display("FAIL r0_after_busy got=%b exp=%b", rd_busy[0], e[0]); end
  endtask

  task automatic test_scoreboard();
    drive_claim(7); #1;
    exp_q.push_back(64'h1); exp_q.push_back(64'h1);
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL sb_claim1_ok got=%b exp=%b", claim_ok, e[0]); end
    tick(); set_rd(7, 7); #1;
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL sb_pend1 got=%0d exp=%0d", pend_cnt, e[5:0]); end
    // second claim on a pending register is refused
    exp_q.push_back(64'h0); exp_q.push_back(64'h3); exp_q.push_back(64'h1);
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL sb_claim2_ok got=%b exp=%b", claim_ok, e[0]); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL sb_busy got=%b exp=%b", rd_busy, e[1:0]); end
    tick(); idle();
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL sb_pend2 got=%0d exp=%0d", pend_cnt, e[5:0]); end
    drive_wb(7, 32'h55); #1;
    exp_q.push_back(BYP ? 64'h0 : 64'h1); exp_q.push_back(BYP ? 64'h55 : 64'h0);
    e = exp_q.pop_front(); total++; if (rd_busy[0] !== e[0]) begin bad++; $display("FAIL sb_wb_busy got=%b exp=%b", rd_busy[0], e[0]); end
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL sb_wb_rd got=%h exp=%h", rd_data[31:0], e[31:0]); end
    exp_q.push_back(64'h0); exp_q.push_back(64'h55); exp_q.push_back(64'h0);
    tick(); idle(); #1;
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL sb_after_busy got=%b exp=%b", rd_busy, e[1:0]); end
    e = exp_q.pop_front(); total++; if (rd_data[63:32] !== e[31:0]) begin bad++; $display("FAIL sb_after_rd got=%h exp=%h", rd_data[63:32], e[31:0]); end
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL sb_after_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
  endtask

  task automatic test_simultaneous();
    drive_claim(9);
    tick();
    drive_wb(9, 32'hA5); drive_claim(9); set_rd(9, 9); #1;
    exp_q.push_back(64'h1);
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL sim_claim_ok got=%b exp=%b", claim_ok, e[0]); end
    exp_q.push_back(64'h1); exp_q.push_back(64'h3); exp_q.push_back(64'hA5);
    tick(); idle(); #1;
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL sim_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL sim_busy got=%b exp=%b", rd_busy, e[1:0]); end
    e = exp_q.pop_front(); total++; if (rd_data[31:0] !== e[31:0]) begin bad++; $display("FAIL sim_rd got=%h exp=%h", rd_data[31:0], e[31:0]); end
    drive_wb(9, 32'hA5);
    exp_q.push_back(64'h0);
    tick(); idle();
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL sim_clear_pend got=%0d exp=%0d", pend_cnt, e[5:0]); end
  endtask

  task automatic test_flush();
    drive_wb(2, 32'h22); tick();
    drive_wb(4, 32'h11); tick(); idle();
    drive_claim(1); tick();
    drive_claim(2); tick();
    drive_claim(4); tick(); idle();
    exp_q.push_back(64'h3);
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL fl_pend3 got=%0d exp=%0d", pend_cnt, e[5:0]); end
    flush = 1'b1; drive_claim(6); drive_wb(4, 32'h44); #1;
    exp_q.push_back(64'h1);
    e = exp_q.pop_front(); total++; if (claim_ok !== e[0]) begin bad++; $display("FAIL fl_claim_ok got=%b exp=%b", claim_ok, e[0]); end
    exp_q.push_back(64'h0); exp_q.push_back(64'h0000_0000_0000_0022); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0000_0000_0000_0044); exp_q.push_back(64'h0);
    tick(); idle(); set_rd(2, 6); #1;
    e = exp_q.pop_front(); total++; if (pend_cnt !== e[5:0]) begin bad++; $display("FAIL fl_pend0 got=%0d exp=%0d", pend_cnt, e[5:0]); end
    e = exp_q.pop_front(); total++; if (rd_data !== e) begin bad++; $display("FAIL fl_rd_2_6 got=%h exp=%h", rd_data, e); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL fl_busy_2_6 got=%b exp=%b", rd_busy, e[1:0]); end
    set_rd(4, 1); #1;
    e = exp_q.pop_front(); total++; if (rd_data !== e) begin bad++; $display("FAIL fl_rd_4_1 got=%h exp=%h", rd_data, e); end
    e = exp_q.pop_front(); total++; if (rd_busy !== e[1:0]) begin bad++; $display("FAIL fl_busy_4_1 got=%b exp=%b", rd_busy, e[1:0]); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] mdl [NREGS];
    logic [AW-1:0]   s;
    logic [XLEN-1:0] d;
    @(negedge clk); reset_n = 1'b0; idle();
    for (int k = 0; k < NREGS; k++) mdl[k] = '0;
    @(negedge clk); reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s = AW'($urandom_range(0, NREGS - 1));
      d = $urandom;
      drive_wb(s, d);
      if (s != 0) mdl[s] = d;
      tick();
    end
    idle();
    for (int r = 0; r < NREGS; r += 2) begin
      set_rd(AW'(r), AW'(r + 1));
      exp_q.push_back({mdl[r + 1], mdl[r]});
      #1;
      e = exp_q.pop_front(); total++; if (rd_data !== e) begin bad++; $display("FAIL b2b_rd r%0d got=%h exp=%h", r, rd_data, e); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    rd_sel = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor register file for the multicycle core.
- Configurable data width, register count and number of read ports.
- Integrated write-pending scoreboard: the issue stage claims a destination register when a multi-cycle op (AHB load) launches; writeback releases it; the decode stage stalls on busy sources.
- Sits between decode (reads, claims) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy; 0 = register 0 is ordinary.
- Derived: AW = $clog2(NREGS).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_sel  in  NRD*AW  read select; port i = bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  per-port source-pending flag.
- wb_en  in  1  writeback strobe.
- wb_sel  in  AW  writeback register.
- wb_data  in  XLEN  writeback data.
- claim_en  in  1  issue-stage claim request.
- claim_sel  in  AW  register to mark pending.
- claim_ok  out  1  claim accepted this cycle (combinational).
- flush  in  1  synchronous clear of all pending bits; data is unchanged.
- pend_cnt  out  AW+1  registered count of pending registers.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers = 0, all pending bits = 0, pend_cnt = 0.
  - As a result, rd_data = 0, rd_busy = 0 and claim_ok = 1 for any sel.
  - Reset mid-claim or mid-write discards that operation.
- Write:
  - On the clk edge with wb_en=1, reg[wb_sel] <= wb_data and pending[wb_sel] <= 0.
  - If ZERO_REG=1 and wb_sel=0, the write is ignored.
- Read: combinational, zero latency.
  - rd_data[i] = 0 if ZERO_REG=1 and sel=0; otherwise bypass value (see Optional Feature) or reg[sel].
- Busy:
  - rd_busy[i] = pending[sel_i] && !bypass_hit_i.
  - Always 0 for register 0 when ZERO_REG=1.
- Claim:
  - claim_ok = !(ZERO_REG && claim_sel==0 ? 0 : pending[claim_sel]) || (wb_en && wb_sel==claim_sel).
  - On the edge with claim_en && claim_ok: pending[claim_sel] <= 1.
  - If claim_en && !claim_ok: no state change; the requester must retry.
  - Claim of register 0 with ZERO_REG=1: claim_ok=1, no bit set.
- Simultaneous claim and writeback to the same register: claim wins, pending stays 1, the data write still occurs.
- flush:
  - Has highest priority for pending bits: all cleared, claims that cycle are dropped, pend_cnt <= 0.
  - A wb_en write in the same cycle still updates data.
- pend_cnt:
  - Registered population count of pending bits, equal to the number of ones after the edge.
  - Next value = cnt + set - cleared.
  - Saturation is impossible by construction (max NREGS).
- Multiple read ports may select the same register; each resolves independently.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - bypass_hit_i = wb_en && wb_sel==sel_i (and not register 0 when ZERO_REG=1).
  - On a hit, rd_data[i] = wb_data and rd_busy[i] = 0 in the same cycle.
- Undefined:
  - bypass_hit_i = 0; rd_data returns the stored value.
  - rd_busy stays 1 until the edge after the writeback.
  - This gives one extra stall cycle per dependent load.

Test Plan:
- Reset: drive reset_n=0 mid-cycle with pending bits set -> immediately rd_data=0, rd_busy=0, pend_cnt=0; after release, read r5 -> 0.
- Write/read: wb_en, wb_sel=3, wb_data=0xDEADBEEF; next cycle rd_sel port0=3, port1=3 -> both 0xDEADBEEF, busy=0.
- Register 0: write 0x1234 to r0, claim r0 -> rd_data=0, rd_busy=0, claim_ok=1, pend_cnt unchanged.
- Scoreboard:
  - Claim r7 -> pend_cnt=1, rd_busy=1 for sel=7.
  - Second claim r7 -> claim_ok=0, pend_cnt still 1.
  - Writeback r7=0x55 -> busy clears (same cycle with BYPASS_EN, next cycle without).
  - pend_cnt then 0.
- Simultaneous: r9 pending; same cycle claim r9 + wb r9=0xA5 -> claim_ok=1, data=0xA5, r9 still busy, pend_cnt=1.
- Flush: claim r1,r2,r4 -> pend_cnt=3; flush with claim r6 same cycle -> pend_cnt=0, no busy bits, register data unchanged.
